// File: rtl/pipeline_pkg.sv
// Shared pipeline types: widths, NOP encoding, fetch FSM state, IF/ID bundle.
// Imported by every fetch-side module and by the bench.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus: req, addr (master out), ack, rdata (in).
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  import pipeline_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: en=0 holds, bubble loads a NOP, else loads d.
// Ports: clk, rst_n (async low), en, bubble, d, q.
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUB = '{
    instr: BUBBLE_INSTR,
    pc4:   '0,
    valid: 1'b0
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUB;
    end else if (en) begin
      q <= bubble ? BUB : d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, variable-latency imem fetch FSM, redirect/stall, IF/ID reg.
// Ports: clk, reset (async low), hazard/redirect inputs, imem bus, IF/ID outs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IFID_WriteEn,
  input  logic                 Stall_flush,
  input  logic                 branchselect,
  input  logic [31:0]          PCbranch,
  fetch_stage_if.master        imem,
  output logic [31:0]          PC_out,
  output logic [31:0]          instruction,
  output logic [31:0]          ID_Instruction,
  output logic [31:0]          ID_PC4,
  output logic                 ID_valid
);
  import pipeline_pkg::*;

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0]  pc, pc_nxt, pc_plus4;
  logic [ADDR_W-1:0]  req_addr, req_addr_nxt;
  logic [INSTR_W-1:0] hold_buf, hold_nxt;
  logic               req;
  logic               have_data;
  logic               redirect;
  logic               id_bubble;
  if_id_t             id_d, id_q;

  assign pc_plus4 = pc + 32'd4;
  // A redirect only counts when the hazard unit lets the stage advance.
  assign redirect = IFID_WriteEn & branchselect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      hold_buf <= NOP_INSTR;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      hold_buf <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    hold_nxt     = hold_buf;
    req          = 1'b0;
    instruction  = NOP_INSTR;
    have_data    = 1'b0;

    unique case (state)
      IDLE: begin
        state_nxt    = FETCH;
        req_addr_nxt = pc;
      end

      FETCH: begin
        req = 1'b1;
        if (imem.ack) begin
          instruction = imem.rdata;
          have_data   = 1'b1;
        end
        unique case (1'b1)
          imem.ack & ~IFID_WriteEn: begin
            hold_nxt  = imem.rdata;
            state_nxt = HOLD;
          end
          imem.ack & redirect: begin
            pc_nxt       = PCbranch;
            req_addr_nxt = PCbranch;
          end
          // Request still in flight: keep addr, wait it out.
          ~imem.ack & redirect: begin
            pc_nxt    = PCbranch;
            state_nxt = DRAIN;
          end
          imem.ack & IFID_WriteEn & ~branchselect: begin
            pc_nxt       = pc_plus4;
            req_addr_nxt = pc_plus4;
          end
          default: ;
        endcase
      end

      HOLD: begin
        instruction = hold_buf;
        have_data   = 1'b1;
        if (IFID_WriteEn) begin
          pc_nxt       = branchselect ? PCbranch : pc_plus4;
          req_addr_nxt = branchselect ? PCbranch : pc_plus4;
          state_nxt    = FETCH;
        end
      end

      DRAIN: begin
        req = 1'b1;
        if (redirect) begin
          pc_nxt = PCbranch;
        end
        if (imem.ack) begin
          state_nxt    = FETCH;
          req_addr_nxt = redirect ? PCbranch : pc;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign imem.req  = req;
  assign imem.addr = req_addr;
  assign PC_out    = pc;

  assign id_bubble = Stall_flush | branchselect | ~have_data;

  assign id_d = '{
    instr: instruction,
    pc4:   pc_plus4,
    valid: 1'b1
  };

  ifid_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk    (clk),
    .rst_n  (reset),
    .en     (IFID_WriteEn),
    .bubble (id_bubble),
    .d      (id_d),
    .q      (id_q)
  );

  assign ID_Instruction = id_q.instr;
  assign ID_PC4         = id_q.pc4;
  assign ID_valid       = id_q.valid;

endmodule
